// File: rtl/stage_controller_multi_pkg.sv
// stage_controller_multi_pkg
//   Shared definitions for the stage controller: the broadcast stage width
//   and the stage encodings seen by the child decoder regions.
package stage_controller_multi_pkg;

  localparam int STAGE_WIDTH = 3;

  typedef enum logic [STAGE_WIDTH-1:0] {
    ST_IDLE                = 3'd0,
    ST_MEASUREMENT_LOADING = 3'd1,
    ST_GROW                = 3'd2,
    ST_MERGE               = 3'd3,
    ST_PEELING             = 3'd4,
    ST_RESULT_VALID        = 3'd5
  } stage_e;

  // Stages in which child status strobes are collected.
  function automatic logic is_collect_stage(input stage_e st);
    return (st == ST_MERGE) || (st == ST_PEELING);
  endfunction

endpackage

// File: rtl/stage_controller_multi_report_collector.sv
// stage_report_collector
//   Captures per-child status while the controller is in a collecting stage
//   and reduces it to all-reported / any-busy / any-odd summaries.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   clear_i          : drop all captured state (stage entry)
//   enable_i         : strobes are accepted only while high
//   valid_i/busy_i/odd_i : per-child strobe and qualified flags
//   all_reported_o   : every child has strobed since the last clear
//   any_busy_o/any_odd_o : OR over reported children's latest flags
module stage_report_collector #(
  parameter int CHILD_COUNT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic [CHILD_COUNT-1:0] valid_i,
  input  logic [CHILD_COUNT-1:0] busy_i,
  input  logic [CHILD_COUNT-1:0] odd_i,
  output logic                   all_reported_o,
  output logic                   any_busy_o,
  output logic                   any_odd_o
);

  logic [CHILD_COUNT-1:0] reported_q;
  logic [CHILD_COUNT-1:0] busy_q;
  logic [CHILD_COUNT-1:0] odd_q;

  for (genvar i = 0; i < CHILD_COUNT; i++) begin : g_child
    always_ff @(posedge clk) begin
      if (reset || clear_i) begin
        reported_q[i] <= 1'b0;
        busy_q[i]     <= 1'b0;
        odd_q[i]      <= 1'b0;
      end else if (enable_i && valid_i[i]) begin
        // Latest strobe wins; earlier busy/odd for this child is overwritten.
        reported_q[i] <= 1'b1;
        busy_q[i]     <= busy_i[i];
        odd_q[i]      <= odd_i[i];
      end
    end
  end

  assign all_reported_o = &reported_q;
  assign any_busy_o     = |(reported_q & busy_q);
  assign any_odd_o      = |(reported_q & odd_q);

endmodule

// File: rtl/stage_controller_multi.sv
// stage_controller_multi
//   Round sequencer broadcasting a global stage to child decoder regions:
//   IDLE -> MEASUREMENT_LOADING -> GROW -> MERGE (-> GROW ...) -> PEELING
//   -> RESULT_VALID -> IDLE. MERGE/PEELING wait for a minimum settle time and
//   for every child to report not-busy.
//   Optional build macro STAGE_CTRL_TIMEOUT_EN: aborts a round into
//   RESULT_VALID with timeout=1 once iteration_counter reaches MAX_ITERATIONS
//   and MERGE would grow again. Without it, timeout is tied low.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   new_round_start       : round request pulse (ignored while result held)
//   child_report_valid/busy/odd_clusters : per-child status
//   global_stage          : broadcast stage encoding
//   result_valid          : held until the cycle after result_ack
//   result_ack            : consumer acceptance
//   iteration_counter     : GROW entries this round
//   cycle_counter         : round latency, saturating
//   timeout               : round ended on iteration limit
module stage_controller_multi
  import stage_controller_multi_pkg::*;
#(
  parameter int CHILD_COUNT             = 4,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int MAXIMUM_DELAY           = 2,
  parameter int LOADING_CYCLES          = 1,
  parameter int MAX_ITERATIONS          = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               new_round_start,
  input  logic [CHILD_COUNT-1:0]             child_report_valid,
  input  logic [CHILD_COUNT-1:0]             child_busy,
  input  logic [CHILD_COUNT-1:0]             child_odd_clusters,
  output logic [STAGE_WIDTH-1:0]             global_stage,
  output logic                               result_valid,
  input  logic                               result_ack,
  output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
  output logic [31:0]                        cycle_counter,
  output logic                               timeout
);

  localparam int ICW = ITERATION_COUNTER_WIDTH;
  localparam int LW  = (LOADING_CYCLES > 1) ? $clog2(LOADING_CYCLES) : 1;
  localparam int SW  = $clog2(MAXIMUM_DELAY + 2);
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOADING_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_MIN = SW'(MAXIMUM_DELAY);

  stage_e          stage_q, stage_d;
  logic [LW-1:0]   load_q;
  logic [SW-1:0]   settle_q;
  logic [ICW-1:0]  iter_q;
  logic [31:0]     cyc_q;
  logic            result_valid_q;
  logic            timeout_hit;

  logic            entering;
  logic            coll_clear, coll_en;
  logic            all_reported, any_busy, any_odd;
  logic            settled;

  assign entering   = (stage_d != stage_q);
  // Clear on entering MERGE/PEELING (including MERGE->PEELING) so each
  // collecting stage sees only its own reports.
  assign coll_clear = entering && is_collect_stage(stage_d);
  assign coll_en    = is_collect_stage(stage_q);

  stage_report_collector #(
    .CHILD_COUNT(CHILD_COUNT)
  ) u_collector (
    .clk            (clk),
    .reset          (reset),
    .clear_i        (coll_clear),
    .enable_i       (coll_en),
    .valid_i        (child_report_valid),
    .busy_i         (child_busy),
    .odd_i          (child_odd_clusters),
    .all_reported_o (all_reported),
    .any_busy_o     (any_busy),
    .any_odd_o      (any_odd)
  );

  assign settled = (settle_q >= SETTLE_MIN) && all_reported && !any_busy;

`ifdef STAGE_CTRL_TIMEOUT_EN
  localparam logic [ICW-1:0] ITER_LIMIT = ICW'(MAX_ITERATIONS);
  logic timeout_q;

  assign timeout_hit = (iter_q == ITER_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (stage_q == ST_IDLE && stage_d == ST_MEASUREMENT_LOADING) begin
      timeout_q <= 1'b0;
    end else if (stage_q == ST_MERGE && stage_d == ST_RESULT_VALID) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    stage_d = stage_q;
    case (stage_q)
      ST_IDLE:
        if (new_round_start && !result_valid_q) stage_d = ST_MEASUREMENT_LOADING;
      ST_MEASUREMENT_LOADING:
        if (load_q == LOAD_LAST) stage_d = ST_GROW;
      ST_GROW:
        stage_d = ST_MERGE;
      ST_MERGE:
        if (settled) begin
          if (!any_odd)        stage_d = ST_PEELING;
          else if (timeout_hit) stage_d = ST_RESULT_VALID;
          else                 stage_d = ST_GROW;
        end
      ST_PEELING:
        if (settled) stage_d = ST_RESULT_VALID;
      ST_RESULT_VALID:
        stage_d = ST_IDLE;
      default:
        stage_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q        <= ST_IDLE;
      load_q         <= '0;
      settle_q       <= '0;
      iter_q         <= '0;
      cyc_q          <= '0;
      result_valid_q <= 1'b0;
    end else begin
      stage_q <= stage_d;

      load_q <= (stage_q == ST_MEASUREMENT_LOADING) ? load_q + 1'b1 : '0;

      if (entering)
        settle_q <= '0;
      else if (coll_en && settle_q < SETTLE_MIN)
        settle_q <= settle_q + 1'b1;

      if (stage_d == ST_MEASUREMENT_LOADING)
        iter_q <= '0;
      else if (stage_d == ST_GROW && stage_q != ST_GROW)
        iter_q <= iter_q + 1'b1;

      // Latency reads 1 throughout loading, then counts working cycles and
      // freezes once the round leaves PEELING/MERGE.
      if (stage_d == ST_MEASUREMENT_LOADING)
        cyc_q <= 32'd1;
      else if ((stage_q == ST_GROW || coll_en) && cyc_q != '1)
        cyc_q <= cyc_q + 32'd1;

      if (stage_d == ST_RESULT_VALID && stage_q != ST_RESULT_VALID)
        result_valid_q <= 1'b1;
      else if (result_ack && result_valid_q)
        result_valid_q <= 1'b0;
    end
  end

  assign global_stage      = stage_q;
  assign result_valid      = result_valid_q;
  assign iteration_counter = iter_q;
  assign cycle_counter     = cyc_q;

endmodule

// File: tb/tb_stage_controller_multi.sv
// Directed bench for stage_controller_multi: expected round results are
// queued at round start and popped when the DUT raises RESULT_VALID.
module tb_stage_controller_multi;
  import stage_controller_multi_pkg::*;

  localparam int CC = 4;
  localparam int MD = 2;
  localparam int LC = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          new_round_start;
  logic [CC-1:0] child_report_valid, child_busy, child_odd_clusters;
  logic [2:0]    global_stage;
  logic          result_valid, result_ack;
  logic [7:0]    iteration_counter;
  logic [31:0]   cycle_counter;
  logic          timeout;

  always #5 clk = ~clk;

  stage_controller_multi #(
    .CHILD_COUNT(CC), .ITERATION_COUNTER_WIDTH(8), .MAXIMUM_DELAY(MD),
    .LOADING_CYCLES(LC), .MAX_ITERATIONS(3)
  ) dut (
    .clk(clk), .reset(reset), .new_round_start(new_round_start),
    .child_report_valid(child_report_valid), .child_busy(child_busy),
    .child_odd_clusters(child_odd_clusters), .global_stage(global_stage),
    .result_valid(result_valid), .result_ack(result_ack),
    .iteration_counter(iteration_counter), .cycle_counter(cycle_counter),
    .timeout(timeout)
  );

  typedef struct { int iter; int cnt; bit to; } exp_t;
  exp_t sb[$];
  int n_pass = 0, n_total = 0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic sb_push(input int iter, input int cnt, input bit to);
    exp_t e;
    e.iter = iter; e.cnt = cnt; e.to = to;
    sb.push_back(e);
  endtask

  // Pulse start from IDLE and walk through loading into the first MERGE.
  task automatic start_round(input string tag);
    new_round_start = 1'b1;
    tick;
    new_round_start = 1'b0;
    chk({tag, "_loading"}, global_stage, ST_MEASUREMENT_LOADING);
    chk({tag, "_cyc_load"}, cycle_counter, 1);
    chk({tag, "_iter_clr"}, iteration_counter, 0);
    for (int i = 0; i < LC; i++) tick;
    chk({tag, "_grow"}, global_stage, ST_GROW);
    chk({tag, "_iter1"}, iteration_counter, 1);
    tick;
    chk({tag, "_merge"}, global_stage, ST_MERGE);
  endtask

  // Serve one MERGE/PEELING stage. All children strobe at k=0 unless
  // late_k>0 (child 3 then strobes at late_k); busy_seq makes child 0 report
  // busy at k=0 and free at k=3.
  task automatic serve(input string tag, input logic [CC-1:0] odd_v,
                       input int late_k, input bit busy_seq, input logic [2:0] exp_next);
    logic [2:0] st0;
    int k, last, exp_cyc;
    st0  = global_stage;
    k    = 0;
    last = 0;
    if (late_k > last) last = late_k;
    if (busy_seq && last < 3) last = 3;
    exp_cyc = ((MD > last + 1) ? MD : last + 1) + 1;
    do begin
      child_report_valid = '0;
      child_busy         = '0;
      child_odd_clusters = odd_v;
      if (k == 0) begin
        child_report_valid = (late_k > 0) ? 4'b0111 : 4'b1111;
        if (busy_seq) child_busy = 4'b0001;
      end
      if (late_k > 0 && k == late_k) child_report_valid = 4'b1000;
      if (busy_seq && k == 3) child_report_valid = 4'b0001;
      tick;
      k++;
    end while (global_stage == st0 && k < 40);
    child_report_valid = '0;
    child_busy         = '0;
    child_odd_clusters = '0;
    chk({tag, "_len"}, k, exp_cyc);
    chk({tag, "_next"}, global_stage, exp_next);
  endtask

  // At RESULT_VALID: pop the scoreboard, check hold behaviour and ack.
  task automatic finish_round(input string tag, input bit try_start);
    exp_t e;
    logic [31:0] cyc_snap;
    chk({tag, "_rv_stage"}, global_stage, ST_RESULT_VALID);
    chk({tag, "_rv"}, result_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_iter"}, iteration_counter, e.iter);
      chk({tag, "_cyc"}, cycle_counter, e.cnt);
      chk({tag, "_to"}, timeout, e.to);
    end
    cyc_snap = cycle_counter;
    tick;
    chk({tag, "_idle"}, global_stage, ST_IDLE);
    chk({tag, "_held"}, result_valid, 1);
    if (try_start) begin
      new_round_start = 1'b1;
      tick;
      new_round_start = 1'b0;
      chk({tag, "_start_ign"}, global_stage, ST_IDLE);
    end
    tick; tick;
    chk({tag, "_held2"}, result_valid, 1);
    chk({tag, "_cyc_frz"}, cycle_counter, cyc_snap);
    result_ack = 1'b1;
    tick;
    result_ack = 1'b0;
    chk({tag, "_acked"}, result_valid, 0);
    result_ack = 1'b1;
    tick;
    result_ack = 1'b0;
    chk({tag, "_ack_idle"}, global_stage, ST_IDLE);
  endtask

  initial begin
    reset = 1'b1; new_round_start = 1'b0; result_ack = 1'b0;
    child_report_valid = '0; child_busy = '0; child_odd_clusters = '0;
    tick; tick; tick;
    reset = 1'b0;
    tick;
    chk("rst_stage", global_stage, ST_IDLE);
    chk("rst_rv", result_valid, 0);
    chk("rst_iter", iteration_counter, 0);
    chk("rst_cyc", cycle_counter, 0);
    chk("rst_to", timeout, 0);

    // Basic round: MERGE 3, PEELING 3 -> 1+1+3+3.
    sb_push(1, 8, 0);
    start_round("r1");
    serve("r1_merge", 4'b0000, 0, 0, ST_PEELING);
    serve("r1_peel", 4'b0000, 0, 0, ST_RESULT_VALID);
    finish_round("r1", 0);

    // Late child 3 and odd from child 1: MERGE 7, GROW, MERGE 3, PEELING 3.
    sb_push(2, 16, 0);
    start_round("r2");
    serve("r2_merge_late", 4'b0010, 5, 0, ST_GROW);
    chk("r2_iter2", iteration_counter, 2);
    tick;
    chk("r2_merge2", global_stage, ST_MERGE);
    serve("r2_merge2", 4'b0000, 0, 0, ST_PEELING);
    serve("r2_peel", 4'b0000, 0, 0, ST_RESULT_VALID);
    finish_round("r2", 0);

    // Busy then free: MERGE 5, PEELING 3; start while result held ignored.
    sb_push(1, 10, 0);
    start_round("r3");
    serve("r3_merge_busy", 4'b0000, 0, 1, ST_PEELING);
    serve("r3_peel", 4'b0000, 0, 0, ST_RESULT_VALID);
    finish_round("r3", 1);

    // After ack a new start is accepted and the latency reloads to 1.
    sb_push(1, 8, 0);
    start_round("r4");
    serve("r4_merge", 4'b0000, 0, 0, ST_PEELING);
    serve("r4_peel", 4'b0000, 0, 0, ST_RESULT_VALID);
    finish_round("r4", 0);

    // Reset in MERGE aborts without a result.
    start_round("r5");
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("r5_stage", global_stage, ST_IDLE);
    chk("r5_rv", result_valid, 0);
    chk("r5_iter", iteration_counter, 0);
    chk("r5_cyc", cycle_counter, 0);
    chk("r5_to", timeout, 0);
    tick; tick;
    chk("r5_no_rv", result_valid, 0);
    chk("r5_still_idle", global_stage, ST_IDLE);

`ifdef STAGE_CTRL_TIMEOUT_EN
    // Odd forever: the third MERGE hits the limit -> 1+3*(1+3).
    sb_push(3, 13, 1);
    start_round("r6");
    serve("r6_m1", 4'b1111, 0, 0, ST_GROW);
    tick;
    serve("r6_m2", 4'b1111, 0, 0, ST_GROW);
    tick;
    serve("r6_m3", 4'b1111, 0, 0, ST_RESULT_VALID);
    finish_round("r6", 0);
    sb_push(1, 8, 0);
    start_round("r7");
    chk("r7_to_clr", timeout, 0);
    serve("r7_merge", 4'b0000, 0, 0, ST_PEELING);
    serve("r7_peel", 4'b0000, 0, 0, ST_RESULT_VALID);
    finish_round("r7", 0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stage_controller_multi.md
STAGE_CONTROLLER_MULTI -- requirements
Module: stage_controller_multi

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CHILD_COUNT, 4: child decoder regions reporting status.
- ITERATION_COUNTER_WIDTH, 8: iteration counter width.
- MAXIMUM_DELAY, 2: minimum settle cycles in MERGE/PEELING.
- LOADING_CYCLES, 1: cycles spent in MEASUREMENT_LOADING (≥1).
- MAX_ITERATIONS, 255: grow limit (timeout build only).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: sole clock.
- reset, in, 1: synchronous, active-high.
- new_round_start, in, 1: round request pulse.
- child_report_valid, in, CHILD_COUNT: per-child status strobe.
- child_busy, in, CHILD_COUNT: busy flag, qualified by strobe.
- child_odd_clusters, in, CHILD_COUNT: odd-cluster flag, qualified by strobe.
- global_stage, out, STAGE_WIDTH: broadcast stage.
- result_valid, out, 1: round result ready, held.
- result_ack, in, 1: consumer acceptance.
- iteration_counter, out, ITERATION_COUNTER_WIDTH: grow count.
- cycle_counter, out, 32: round latency in cycles.
- timeout, out, 1: round aborted on iteration limit.
REQ-003 One clock; reset is synchronous and active-high.

Function
REQ-010 States SHALL be IDLE, MEASUREMENT_LOADING, GROW, MERGE, PEELING, RESULT_VALID.
REQ-011 IDLE: new_round_start while result_valid=0 -> MEASUREMENT_LOADING; new_round_start with result_valid=1 SHALL be ignored (not queued).
REQ-012 MEASUREMENT_LOADING SHALL last exactly LOADING_CYCLES cycles, then GROW.
REQ-013 GROW SHALL last one cycle, then MERGE; each GROW entry increments iteration_counter (wraps modulo 2^ITERATION_COUNTER_WIDTH).
REQ-014 On MERGE/PEELING entry the collector SHALL clear; a child is "reported" once its strobe is seen; latest strobe per child overwrites its busy/odd.
REQ-015 MERGE exit only when settle count ≥ MAXIMUM_DELAY, all children reported, and OR of reported busy = 0; then odd OR = 1 -> GROW, else PEELING.
REQ-016 PEELING exit on the same MERGE condition (odd ignored) -> RESULT_VALID.
REQ-017 RESULT_VALID SHALL last one cycle, set result_valid=1, then IDLE.
REQ-018 result_valid SHALL stay 1 until the cycle after result_ack=1; result_ack with result_valid=0 SHALL have no effect.
REQ-019 cycle_counter SHALL load 1 in MEASUREMENT_LOADING, increment each cycle in GROW/MERGE/PEELING, and freeze from RESULT_VALID until next round; saturate at 2^32-1.
REQ-020 iteration_counter SHALL clear in MEASUREMENT_LOADING and hold after the round.
REQ-021 Strobes in states other than MERGE/PEELING SHALL be ignored.
REQ-022 Undefined stage encoding SHALL go to IDLE next cycle.

Reset
REQ-030 reset SHALL force global_stage=IDLE, result_valid=0, timeout=0, iteration_counter=0, cycle_counter=0, collector cleared, settle counter 0, next cycle, any state.
REQ-031 reset mid-round SHALL abort with no result_valid.

Configuration
REQ-040 With STAGE_CTRL_TIMEOUT_EN defined: a MERGE exit to GROW with iteration_counter = MAX_ITERATIONS SHALL go to RESULT_VALID with timeout=1; timeout clears on next MEASUREMENT_LOADING or reset.
REQ-041 Without STAGE_CTRL_TIMEOUT_EN: no iteration limit, timeout tied 0, MAX_ITERATIONS unused.

Structure
REQ-050 STAGE_WIDTH=3 and stage constants (IDLE=0, MEASUREMENT_LOADING=1, GROW=2, MERGE=3, PEELING=4, RESULT_VALID=5) SHALL live in the shared parameters package.
REQ-051 Per-child reported/busy/odd capture plus all-reported/any-busy/any-odd reduction SHALL be sub-module stage_report_collector.

Verification
REQ-060 Single child, no odd: start -> LOADING, GROW, MERGE after 2 settle cycles plus report -> PEELING -> RESULT_VALID; iteration_counter=1; result_valid held until ack.
REQ-061 CHILD_COUNT=4, child 3 reports 5 cycles late: MERGE holds until its strobe; odd from child 1 only -> GROW, iteration_counter=2.
REQ-062 Child reports busy=1 then busy=0: exit only after second strobe.
REQ-063 new_round_start while result_valid=1 -> ignored; after ack, start accepted; cycle_counter reloads 1.
REQ-064 Timeout build, MAX_ITERATIONS=3, odd always 1 -> after 3rd MERGE, RESULT_VALID, timeout=1, iteration_counter=3.
REQ-065 reset asserted in MERGE -> IDLE next cycle, all outputs 0, no result_valid.
